keycode_input: RTL and testbench
================================

KEYCODE_INPUT -- requirements
Module: keycode_input

Interface
REQ-001 The block SHALL have parameter DAS_CYCLES, default 8000000, giving the delay from first shift pulse to first auto-repeat (160 ms at 50 MHz).
REQ-002 The block SHALL have parameter ARR_CYCLES, default 2500000, giving the period between shift auto-repeat pulses.
REQ-003 The block SHALL have parameter SOFT_CYCLES, default 1500000, giving the period between soft-drop repeat pulses.
REQ-004 clk  input  1  system clock; MAX10_CLK1_50 domain.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 keycode  input  8  USB HID keycode from the SoC keycode PIO; 0x00 means no key.
REQ-007 enable  input  1  high while a piece is falling; gates all outputs.
REQ-008 moveLeft, moveRight  output  1 each  single-cycle shift pulses.
REQ-009 rotate  output  1  single-cycle rotate pulse.
REQ-010 softDrop  output  1  single-cycle soft-drop pulse.
REQ-011 hardDrop  output  1  single-cycle hard-drop pulse.
REQ-012 repeating  output  1  high while the shift engine is in state REPEAT.

Function
REQ-013 Keycode map SHALL be: 0x04 or 0x50 -> left; 0x07 or 0x4F -> right; 0x1A or 0x52 -> rotate; 0x16 or 0x51 -> soft drop; 0x2C -> hard drop; any other code -> none.
REQ-014 keycode SHALL be registered into kc_q each cycle; a press is detected when the decoded class of kc_q differs from that of the previous kc_q.
REQ-015 All outputs SHALL be registered; a press of keycode at edge N SHALL produce its pulse high for exactly the cycle following edge N+1 (two-edge latency).
REQ-016 At most one of the five pulse outputs SHALL be high in any cycle.
REQ-017 The shift engine SHALL have states IDLE, DAS and REPEAT, plus a 24-bit down-counter.
REQ-018 IDLE -> DAS on a left/right press: emit one shift pulse and load the counter with DAS_CYCLES-1.
REQ-019 In DAS with the same key held: decrement the counter; at 0, emit a shift pulse, load ARR_CYCLES-1, and go to REPEAT.
REQ-020 In REPEAT with the same key held: decrement the counter; at 0, emit a shift pulse and reload ARR_CYCLES-1.
REQ-021 Direction change (left<->right) in DAS or REPEAT: restart as a fresh press: emit an opposite pulse, load DAS_CYCLES-1, and go to DAS.
REQ-022 Release, or a change to a non-shift class, in DAS or REPEAT SHALL return to IDLE with no pulse in that cycle.
REQ-023 Soft drop SHALL pulse on press, then every SOFT_CYCLES cycles while held, with no DAS delay, using its own counter.
REQ-024 Rotate and hard drop SHALL pulse once per press and never repeat.
REQ-025 enable low SHALL force all pulses low and the shift and soft-drop engines to IDLE and hold them there.
REQ-026 Re-arm when enable rises with a key held:
- shift or soft-drop key held: SHALL be treated as a new press, pulsing two edges later.
- rotate or hard-drop key held: SHALL NOT pulse until the key is released and pressed again.
REQ-027 Counter wrap SHALL be impossible: each counter is only loaded or decremented while nonzero.

Reset
REQ-028 While reset_n is low at a clk edge: all outputs 0, engines in IDLE, counters 0, kc_q and previous kc_q 0x00, and the rotate/hard-drop lockout flags cleared.
REQ-029 Reset mid-DAS or mid-REPEAT SHALL abort with no pulse.
REQ-030 A key held through reset release SHALL be treated as a new press.

Verification
REQ-031 All scenarios SHALL use DAS=10, ARR=4, SOFT=3 and enable=1 unless stated otherwise.
REQ-032 Hold 0x04 for 30 cycles -> moveLeft pulses at cycles 2, 12, 16, 20, 24, 28; repeating high from cycle 12.
REQ-033 0x07 at cycle 0, then 0x04 at cycle 14 -> moveRight at cycles 2 and 12; moveLeft at cycle 16, then at 26.
REQ-034 Hold 0x2C for 20 cycles -> hardDrop only at cycle 2; hold 0x16 for 10 cycles -> softDrop at cycles 2, 5, 8.
REQ-035 Hold 0x1A, drop enable at cycle 5, raise it at cycle 8 -> one rotate pulse at cycle 2 only; release and re-press -> a new pulse two edges after the re-press.
REQ-036 Hold 0x04, assert reset_n=0 at cycle 7 for 2 cycles -> no pulse during reset; moveLeft two edges after release, followed by a full DAS.

Source files
------------

// File: rtl/keycode_input.sv
// Keyboard front end for the falling-piece game: decodes HID keycodes into
// single-cycle move/rotate/drop pulses with DAS/ARR shift repeat and soft-drop repeat.
module keycode_input #(
    parameter int DAS_CYCLES  = 8000000,
    parameter int ARR_CYCLES  = 2500000,
    parameter int SOFT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       rotate,
    output logic       softDrop,
    output logic       hardDrop,
    output logic       repeating
);

    typedef enum logic [2:0] {K_NONE, K_LEFT, K_RIGHT, K_ROT, K_SOFT, K_HARD} key_class_t;
    typedef enum logic [1:0] {IDLE, DAS, REPEAT} shift_state_t;

    localparam logic [23:0] DAS_LOAD  = 24'(DAS_CYCLES - 1);
    localparam logic [23:0] ARR_LOAD  = 24'(ARR_CYCLES - 1);
    localparam logic [23:0] SOFT_LOAD = 24'(SOFT_CYCLES - 1);

    function automatic key_class_t classify(input logic [7:0] kc);
        case (kc)
            8'h04, 8'h50: return K_LEFT;
            8'h07, 8'h4F: return K_RIGHT;
            8'h1A, 8'h52: return K_ROT;
            8'h16, 8'h51: return K_SOFT;
            8'h2C:        return K_HARD;
            default:      return K_NONE;
        endcase
    endfunction

    logic [7:0]   kc_q, kc_prev;
    logic         en_q;
    logic         rot_lock, hard_lock;
    shift_state_t shift_state;
    logic [23:0]  shift_cnt;
    logic         soft_active;
    logic [23:0]  soft_cnt;

    key_class_t cls, prev_cls;
    logic       press, is_shift, gate;

    assign cls      = classify(kc_q);
    assign prev_cls = classify(kc_prev);
    assign press    = (cls != prev_cls);
    assign is_shift = (cls == K_LEFT) || (cls == K_RIGHT);
    // Both the current and the previous enable must be high, so a rising enable
    // re-arms held shift/soft keys with the same two-edge latency as a keypress.
    assign gate     = enable && en_q;

    always_ff @(posedge clk) begin
        // NOTE: every state register is cleared by the synchronous reset and all
        // sequential updates use non-blocking assignments so ordering never matters.
        if (!reset_n) begin
            kc_q        <= 8'h00;
            kc_prev     <= 8'h00;
            en_q        <= 1'b0;
            rot_lock    <= 1'b0;
            hard_lock   <= 1'b0;
            shift_state <= IDLE;
            shift_cnt   <= '0;
            soft_active <= 1'b0;
            soft_cnt    <= '0;
            moveLeft    <= 1'b0;
            moveRight   <= 1'b0;
            rotate      <= 1'b0;
            softDrop    <= 1'b0;
            hardDrop    <= 1'b0;
            repeating   <= 1'b0;
        end else begin
            kc_q      <= keycode;
            kc_prev   <= kc_q;
            en_q      <= enable;
            moveLeft  <= 1'b0;
            moveRight <= 1'b0;
            softDrop  <= 1'b0;

            // A lock stays set while its class is held, even with enable low,
            // so re-enabling never fires a stale rotate or hard drop.
            rot_lock  <= (cls == K_ROT);
            hard_lock <= (cls == K_HARD);
            rotate    <= gate && (cls == K_ROT)  && !rot_lock;
            hardDrop  <= gate && (cls == K_HARD) && !hard_lock;

            if (!gate) begin
                shift_state <= IDLE;
                shift_cnt   <= '0;
                repeating   <= 1'b0;
                soft_active <= 1'b0;
                soft_cnt    <= '0;
            end else begin
                case (shift_state)
                    IDLE: begin
                        if (is_shift) begin
                            moveLeft    <= (cls == K_LEFT);
                            moveRight   <= (cls == K_RIGHT);
                            shift_cnt   <= DAS_LOAD;
                            shift_state <= DAS;
                        end
                    end
                    DAS, REPEAT: begin
                        if (!is_shift) begin
                            shift_state <= IDLE;
                            shift_cnt   <= '0;
                            repeating   <= 1'b0;
                        end else if (press) begin
                            // Direction reversal restarts the full DAS delay.
                            moveLeft    <= (cls == K_LEFT);
                            moveRight   <= (cls == K_RIGHT);
                            shift_cnt   <= DAS_LOAD;
                            shift_state <= DAS;
                            repeating   <= 1'b0;
                        end else if (shift_cnt == '0) begin
                            moveLeft    <= (cls == K_LEFT);
                            moveRight   <= (cls == K_RIGHT);
                            shift_cnt   <= ARR_LOAD;
                            shift_state <= REPEAT;
                            repeating   <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt - 24'd1;
                        end
                    end
                    default: begin
                        shift_state <= IDLE;
                        shift_cnt   <= '0;
                        repeating   <= 1'b0;
                    end
                endcase

                if (!soft_active) begin
                    if (cls == K_SOFT) begin
                        softDrop    <= 1'b1;
                        soft_cnt    <= SOFT_LOAD;
                        soft_active <= 1'b1;
                    end
                end else if (cls != K_SOFT) begin
                    soft_active <= 1'b0;
                    soft_cnt    <= '0;
                end else if (soft_cnt == '0) begin
                    softDrop <= 1'b1;
                    soft_cnt <= SOFT_LOAD;
                end else begin
                    soft_cnt <= soft_cnt - 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keycode_input.sv
// Self-checking bench for keycode_input: directed scenarios with literal pulse
// timings plus randomized stimulus against a timeline-based reference model.
module tb_keycode_input;

    localparam int DAS  = 10;
    localparam int ARR  = 4;
    localparam int SOFT = 3;

    typedef enum int {C_NONE, C_LEFT, C_RIGHT, C_ROT, C_SOFT, C_HARD} cls_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode;
    logic       enable;
    logic       moveLeft, moveRight, rotate, softDrop, hardDrop, repeating;

    int n_cmp = 0;
    int n_bad = 0;

    keycode_input #(
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR),
        .SOFT_CYCLES(SOFT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .keycode  (keycode),
        .enable   (enable),
        .moveLeft (moveLeft),
        .moveRight(moveRight),
        .rotate   (rotate),
        .softDrop (softDrop),
        .hardDrop (hardDrop),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    function automatic cls_t classify(input logic [7:0] kc);
        case (kc)
            8'h04, 8'h50: return C_LEFT;
            8'h07, 8'h4F: return C_RIGHT;
            8'h1A, 8'h52: return C_ROT;
            8'h16, 8'h51: return C_SOFT;
            8'h2C:        return C_HARD;
            default:      return C_NONE;
        endcase
    endfunction

    // Reference model: each held shift/soft key is an episode with a start edge;
    // pulse times follow from the elapsed edge count by plain arithmetic.
    bit   exp_left, exp_right, exp_rot, exp_soft, exp_hard, exp_rep;
    bit   model_live = 0;

    initial begin
        int   e = 0;
        cls_t h1 = C_NONE, h2 = C_NONE;
        bit   en_prev = 0;
        int   sh_start = -1, sf_start = -1;
        cls_t sh_dir = C_NONE;
        forever begin
            @(posedge clk);
            e++;
            exp_left = 0; exp_right = 0; exp_rot = 0;
            exp_soft = 0; exp_hard = 0; exp_rep = 0;
            if (!reset_n) begin
                h1 = C_NONE; h2 = C_NONE; en_prev = 0;
                sh_start = -1; sf_start = -1; sh_dir = C_NONE;
            end else begin
                if (!(enable && en_prev)) begin
                    sh_start = -1;
                    sf_start = -1;
                end else begin
                    if (h1 == C_LEFT || h1 == C_RIGHT) begin
                        int d;
                        if (sh_start < 0 || h1 != sh_dir) begin
                            sh_start = e;
                            sh_dir   = h1;
                        end
                        d = e - sh_start;
                        if (d == 0 || d == DAS || (d > DAS && (d - DAS) % ARR == 0)) begin
                            exp_left  = (h1 == C_LEFT);
                            exp_right = (h1 == C_RIGHT);
                        end
                        exp_rep = (d >= DAS);
                    end else begin
                        sh_start = -1;
                    end
                    if (h1 == C_SOFT) begin
                        if (sf_start < 0) sf_start = e;
                        exp_soft = ((e - sf_start) % SOFT == 0);
                    end else begin
                        sf_start = -1;
                    end
                    exp_rot  = (h1 == C_ROT)  && (h2 != C_ROT);
                    exp_hard = (h1 == C_HARD) && (h2 != C_HARD);
                end
                h2      = h1;
                h1      = classify(keycode);
                en_prev = enable;
            end
            model_live = 1;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model_moveLeft",  moveLeft,  exp_left);
            check("model_moveRight", moveRight, exp_right);
            check("model_rotate",    rotate,    exp_rot);
            check("model_softDrop",  softDrop,  exp_soft);
            check("model_hardDrop",  hardDrop,  exp_hard);
            check("model_repeating", repeating, exp_rep);
            check("onehot", $countones({moveLeft, moveRight, rotate, softDrop, hardDrop}) <= 1, 1'b1);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            keycode = 8'h00;
            enable  = 1'b1;
            reset_n = 1'b1;
        end
    endtask

    logic [7:0] pool [0:9] = '{8'h00, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h2C};

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        keycode = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_moveLeft",  moveLeft,  1'b0);
        check("reset_moveRight", moveRight, 1'b0);
        check("reset_rotate",    rotate,    1'b0);
        check("reset_softDrop",  softDrop,  1'b0);
        check("reset_hardDrop",  hardDrop,  1'b0);
        check("reset_repeating", repeating, 1'b0);
        idle(4);

        // Hold left: DAS then ARR repeats.
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("hold_left_pulse", moveLeft, c inside {2, 12, 16, 20, 24, 28});
            check("hold_left_rep",   repeating, c >= 12);
            keycode = 8'h04;
        end
        idle(5);

        // Right then reverse to left mid-repeat.
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("reverse_right", moveRight, c inside {2, 12});
            check("reverse_left",  moveLeft,  c inside {16, 26});
            keycode = (c < 14) ? 8'h07 : 8'h04;
        end
        idle(5);

        // Hard drop never repeats; soft drop repeats with no DAS.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hard_once", hardDrop, c == 2);
            keycode = 8'h2C;
        end
        idle(5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("soft_repeat", softDrop, c inside {2, 5, 8});
            keycode = 8'h16;
        end
        idle(5);

        // Rotate held across an enable drop, then released and re-pressed.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rotate_lockout", rotate, c inside {2, 16});
            enable  = !(c >= 5 && c < 8);
            keycode = (c >= 12 && c < 14) ? 8'h00 : 8'h1A;
        end
        idle(5);

        // Reset in the middle of DAS with left held.
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            check("reset_mid_das", moveLeft, c inside {2, 11, 21, 25});
            keycode = 8'h04;
            reset_n = !(c == 7 || c == 8);
        end
        idle(5);

        // Randomized traffic against the model.
        begin
            int hold = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                reset_n = ($urandom_range(0, 199) != 0);
                if (!enable) enable = ($urandom_range(0, 3) == 0);
                else         enable = ($urandom_range(0, 49) != 0);
                if (hold == 0) begin
                    if ($urandom_range(0, 9) == 0) keycode = 8'($urandom_range(0, 255));
                    else                           keycode = pool[$urandom_range(0, 9)];
                    hold = $urandom_range(1, 30);
                end else begin
                    hold--;
                end
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
